// File: rtl/mem_burst_if.sv
// Bundle of command, write-stream, read-stream and memory-pin signals around mem_burst_ctrl.
// slave = the burst controller itself, master = the surrounding system/memory.
interface mem_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6
) ();
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              mem_cen;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  start, rw, base_addr, len, wr_data, wr_valid, mem_dout,
        output busy, done, err, wr_ready, rd_data, rd_valid,
        output mem_cen, mem_wen, mem_addr, mem_din
    );

    modport master (
        output start, rw, base_addr, len, wr_data, wr_valid, mem_dout,
        input  busy, done, err, wr_ready, rd_data, rd_valid,
        input  mem_cen, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer: turns one (rw, base, len) command into single-word accesses on a sync memory.
// Optional macro BOUND_CHECK_EN rejects bursts that would run past DEPTH instead of wrapping.
module mem_burst_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32,
    parameter int LEN_W  = 6
) (
    input  logic     clk,
    input  logic     reset_n,
    mem_burst_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [LEN_W:0]  LEN_DEPTH  = (LEN_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ADDR_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_q, err_d;
    logic              mem_cen_q, mem_cen_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              rd_valid_q, rd_valid_d;
    logic              too_long, out_of_range;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + (ADDR_W+1)'(idx);
`ifdef BOUND_CHECK_EN
        return sum[ADDR_W-1:0];
`else
        sum = sum % ADDR_DEPTH;
        return sum[ADDR_W-1:0];
`endif
    endfunction

    assign too_long = {1'b0, bus.len} > LEN_DEPTH;
`ifdef BOUND_CHECK_EN
    assign out_of_range = ({1'b0, bus.base_addr} >= ADDR_DEPTH) ||
                          (({1'b0, bus.base_addr} + (ADDR_W+1)'(bus.len)) > ADDR_DEPTH);
`else
    assign out_of_range = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        base_d     = base_q;
        err_d      = err_q;
        mem_cen_d  = 1'b0;
        mem_wen_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        // Memory output is valid one edge after a read was issued.
        rd_valid_d = mem_cen_q & ~mem_wen_q;

        unique case (state_q)
            IDLE: if (bus.start) begin
                base_d = bus.base_addr;
                len_d  = bus.len;
                idx_d  = '0;
                err_d  = 1'b0;
                if (bus.len == '0) begin
                    state_d = DONE;
                end else if (too_long || out_of_range) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (bus.rw) begin
                    state_d = WRITE;
                end else begin
                    state_d    = READ;
                    mem_cen_d  = 1'b1;
                    mem_addr_d = word_addr(bus.base_addr, '0);
                end
            end
            WRITE: if (bus.wr_valid) begin
                mem_cen_d  = 1'b1;
                mem_wen_d  = 1'b1;
                mem_addr_d = word_addr(base_q, idx_q);
                mem_din_d  = bus.wr_data;
                idx_d      = idx_q + LEN_W'(1);
                if (idx_q + LEN_W'(1) == len_q) state_d = DONE;
            end
            READ: begin
                // idx_q is the word whose address is currently on mem_addr.
                if (idx_q + LEN_W'(1) < len_q) begin
                    idx_d      = idx_q + LEN_W'(1);
                    mem_cen_d  = 1'b1;
                    mem_addr_d = word_addr(base_q, idx_q + LEN_W'(1));
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            err_q      <= 1'b0;
            mem_cen_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            base_q     <= base_d;
            err_q      <= err_d;
            mem_cen_q  <= mem_cen_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = (state_q == DONE) && err_q;
    assign bus.wr_ready = (state_q == WRITE);
    assign bus.rd_data  = bus.mem_dout;
    assign bus.rd_valid = rd_valid_q;
    assign bus.mem_cen  = mem_cen_q;
    assign bus.mem_wen  = mem_wen_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a 32 x 32-bit synchronous memory model behind it.
// Expectations follow BOUND_CHECK_EN when the bench is built with that macro.
module tb_mem_burst_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 32;
    localparam int LEN_W  = 6;

    logic clk = 1'b0;
    logic reset_n;
    logic mem_clear;
    int   vectors = 0;
    int   miscompares = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_dout_q;
    logic [DATA_W-1:0] ev [4];

    always #5 clk = ~clk;

    mem_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    mem_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Synchronous single-port memory; outputs 0 on a write cycle.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD_0000 | DATA_W'(i);
            mem_dout_q <= '0;
        end else if (bus.mem_cen) begin
            if (bus.mem_wen) begin
                mem[bus.mem_addr[4:0]] <= bus.mem_din;
                mem_dout_q <= '0;
            end else begin
                mem_dout_q <= mem[bus.mem_addr[4:0]];
            end
        end
    end
    assign bus.mem_dout = mem_dout_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wrap(input int base, input int i);
        return 32'((base + i) % DEPTH);
    endfunction

    task automatic start_cmd(input logic rw, input logic [7:0] base, input logic [5:0] n);
        bus.start     = 1'b1;
        bus.rw        = rw;
        bus.base_addr = base;
        bus.len       = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] base, input logic [5:0] n, input int gap,
                               input logic [31:0] seed);
        start_cmd(1'b1, base, n);
        check("wr_ready_first", bus.wr_ready, 1);
        check("wr_busy", bus.busy, 1);
        for (int i = 0; i < int'(n); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.wr_valid = 1'b0;
                    @(negedge clk);
                    check("gap_cen", bus.mem_cen, 0);
                    check("gap_done", bus.done, 0);
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = seed + 32'(i);
            @(negedge clk);
            check("wr_cen", bus.mem_cen, 1);
            check("wr_wen", bus.mem_wen, 1);
            check("wr_addr", bus.mem_addr, wrap(int'(base), i));
            check("wr_din", bus.mem_din, seed + 32'(i));
            check("wr_done", bus.done, (i == int'(n) - 1));
            check("wr_ready", bus.wr_ready, (i != int'(n) - 1));
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("wr_after_done", bus.done, 0);
        check("wr_after_busy", bus.busy, 0);
        check("wr_after_cen", bus.mem_cen, 0);
    endtask

    task automatic read_burst(input logic [7:0] base, input logic [5:0] n,
                              input logic [31:0] exp_v [4]);
        start_cmd(1'b0, base, n);
        check("rd_issue_cen", bus.mem_cen, 1);
        check("rd_issue_wen", bus.mem_wen, 0);
        check("rd_issue_addr", bus.mem_addr, wrap(int'(base), 0));
        check("rd_first_valid", bus.rd_valid, 0);
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            check("rd_valid", bus.rd_valid, 1);
            check("rd_data", bus.rd_data, exp_v[i]);
            check("rd_done", bus.done, (i == int'(n) - 1));
            if (i < int'(n) - 1) check("rd_addr", bus.mem_addr, wrap(int'(base), i + 1));
            else                 check("rd_last_cen", bus.mem_cen, 0);
        end
        @(negedge clk);
        check("rd_after_valid", bus.rd_valid, 0);
        check("rd_after_done", bus.done, 0);
        check("rd_after_busy", bus.busy, 0);
    endtask

    task automatic reject(input logic rw, input logic [7:0] base, input logic [5:0] n,
                          input logic exp_err);
        start_cmd(rw, base, n);
        check("rej_done", bus.done, 1);
        check("rej_err", bus.err, exp_err);
        check("rej_busy", bus.busy, 1);
        check("rej_cen", bus.mem_cen, 0);
        check("rej_ready", bus.wr_ready, 0);
        @(negedge clk);
        check("rej_after_done", bus.done, 0);
        check("rej_after_err", bus.err, 0);
        check("rej_after_cen", bus.mem_cen, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_clear     = 1'b1;
        bus.start     = 1'b0;
        bus.rw        = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cen", bus.mem_cen, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_addr", bus.mem_addr, 0);
        reset_n   = 1'b1;
        mem_clear = 1'b0;
        @(negedge clk);

        // Back-to-back write then readback.
        write_burst(8'd4, 6'd3, 0, 32'hA);
        check("mem4", mem[4], 32'hA);
        check("mem6", mem[6], 32'hC);
        ev = '{32'hA, 32'hB, 32'hC, 32'h0};
        read_burst(8'd4, 6'd3, ev);

        // Write with a two-cycle valid gap.
        write_burst(8'd20, 6'd2, 2, 32'h55);
        ev = '{32'h55, 32'h56, 32'h0, 32'h0};
        read_burst(8'd20, 6'd2, ev);

        // Zero-length and over-length commands.
        reject(1'b1, 8'd3, 6'd0, 1'b0);
        reject(1'b0, 8'd3, 6'd40, 1'b1);
        reject(1'b1, 8'd0, 6'd33, 1'b1);

        // Burst crossing the top of the memory.
`ifdef BOUND_CHECK_EN
        reject(1'b0, 8'd30, 6'd4, 1'b1);
        reject(1'b0, 8'd40, 6'd1, 1'b1);
`else
        ev = '{32'hDEAD_001E, 32'hDEAD_001F, 32'hDEAD_0000, 32'hDEAD_0001};
        read_burst(8'd30, 6'd4, ev);
`endif

        // Full-depth length is legal.
        write_burst(8'd0, 6'd32, 0, 32'h1000);
        check("mem31_full", mem[31], 32'h101F);
        write_burst(8'd10, 6'd2, 0, 32'hDEAD_000A);

        // Reset during the second beat of a 5-word write.
        start_cmd(1'b1, 8'd10, 6'd5);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h100;
        @(negedge clk);
        check("abort_beat0_addr", bus.mem_addr, 10);
        bus.wr_data = 32'h101;
        reset_n     = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_cen", bus.mem_cen, 0);
        check("abort_done", bus.done, 0);
        check("abort_ready", bus.wr_ready, 0);
        reset_n      = 1'b1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("abort_no_done", bus.done, 0);
        ev = '{32'h100, 32'hDEAD_000B, 32'h0, 32'h0};
        read_burst(8'd10, 6'd2, ev);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
